pipe_ctrl: RTL and testbench

Central pipeline stall/flush controller for the five-stage Minisys-1A core. It consumes the single-cycle load-use stall request from hazard detection together with the multi-cycle divider, branch and exception events, and produces per-stage write-enable and flush (bubble) strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It also counts stall and flush cycles for performance analysis. It sits beside the pipeline registers and is the only driver of their enable/flush inputs.

---
 rtl/pipe_pkg.sv | 65 ++++++
 rtl/pipe_ctrl_sat_counter.sv | 20 ++
 rtl/pipe_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: controller states, the per-stage strobe
// bundle with its canned values, and the bubble pattern for the ID/EX register.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MD_WAIT   = 2'd1,
    EXC_DRAIN = 2'd2
  } state_t;

  // Stage enable/flush strobes driven onto the pipeline registers
  typedef struct packed {
    logic pc_write;
    logic pc_sel_exc;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } ctl_t;

  // Free-running pipeline, no hazards
  localparam ctl_t CTL_RUN = '{pc_write: 1'b1, pc_sel_exc: 1'b0, if_id_write: 1'b1,
                               if_id_flush: 1'b0, id_ex_flush: 1'b0,
                               ex_mem_flush: 1'b0, mem_wb_flush: 1'b0};

  // Hold PC and IF/ID, push a bubble into EX (load-use or mult/div wait)
  localparam ctl_t CTL_STALL = '{pc_write: 1'b0, pc_sel_exc: 1'b0, if_id_write: 1'b0,
                                 if_id_flush: 1'b0, id_ex_flush: 1'b1,
                                 ex_mem_flush: 1'b0, mem_wb_flush: 1'b0};

  // Taken branch: load the target and squash the two younger instructions
  localparam ctl_t CTL_BRANCH = '{pc_write: 1'b1, pc_sel_exc: 1'b0, if_id_write: 1'b1,
                                  if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                  ex_mem_flush: 1'b0, mem_wb_flush: 1'b0};

  // Exception taken: load the vector and wipe every stage
  localparam ctl_t CTL_EXC = '{pc_write: 1'b1, pc_sel_exc: 1'b1, if_id_write: 1'b1,
                               if_id_flush: 1'b1, id_ex_flush: 1'b1,
                               ex_mem_flush: 1'b1, mem_wb_flush: 1'b1};

  // Follow-on drain cycles after an exception: keep fetching from the vector, flush all
  localparam ctl_t CTL_DRAIN = '{pc_write: 1'b1, pc_sel_exc: 1'b0, if_id_write: 1'b1,
                                 if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                 ex_mem_flush: 1'b1, mem_wb_flush: 1'b1};

  // Held in reset: nothing advances, every register holds a bubble
  localparam ctl_t CTL_RESET = '{pc_write: 1'b0, pc_sel_exc: 1'b0, if_id_write: 1'b0,
                                 if_id_flush: 1'b1, id_ex_flush: 1'b1,
                                 ex_mem_flush: 1'b1, mem_wb_flush: 1'b1};

  // Control fields carried by ID/EX; a bubble has every one of them cleared
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic [3:0] alu_op;
  } ex_ctrl_t;

  localparam ex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count qualifying cycles and stick at all-ones instead of wrapping
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: turns hazard, divider, branch and
// exception events into per-stage enable/flush strobes, and counts stalls
// and flushes. Strobes are combinational so a request acts in its own cycle.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int EXC_FLUSH_CYCLES = 2,
  parameter int CNT_W            = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ID_EX_stall,
  input  logic             id_uses_md,
  input  logic             md_busy,
  input  logic             ex_branch_taken,
  input  logic             mem_exception,
  output logic             pc_write,
  output logic             pc_sel_exc,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DRAIN_W = (EXC_FLUSH_CYCLES > 1) ? $clog2(EXC_FLUSH_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(EXC_FLUSH_CYCLES - 1);

  state_t             state;
  state_t             next_state;
  logic [DRAIN_W-1:0] drain_cnt;
  logic [DRAIN_W-1:0] next_drain;
  ctl_t               ctl;
  logic               stall_inc;
  logic               flush_inc;

  // Decode strobes and next state; exception beats branch beats MD wait beats load-use
  always_comb begin
    ctl        = CTL_RUN;
    next_state = state;
    next_drain = drain_cnt;
    if (reset) begin
      ctl        = CTL_RESET;
      next_state = RUN;
      next_drain = '0;
    end else if (state == EXC_DRAIN) begin
      ctl = CTL_DRAIN;
      if (drain_cnt != '0) begin
        next_drain = drain_cnt - 1'b1;
      end
      if (drain_cnt <= DRAIN_W'(1)) begin
        next_state = RUN;
      end
    end else if (mem_exception) begin
      ctl = CTL_EXC;
      if (EXC_FLUSH_CYCLES > 1) begin
        next_state = EXC_DRAIN;
        next_drain = DRAIN_INIT;
      end else begin
        next_state = RUN;
      end
    end else if (ex_branch_taken) begin
      ctl        = CTL_BRANCH;
      next_state = RUN;
    end else if (md_busy && (id_uses_md || (state == MD_WAIT))) begin
      ctl        = CTL_STALL;
      next_state = MD_WAIT;
    end else if (ID_EX_stall) begin
      ctl        = CTL_STALL;
      next_state = RUN;
    end else begin
      next_state = RUN;
    end
  end

  // Controller state and exception drain counter; reset aborts any wait or drain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= next_state;
      drain_cnt <= next_drain;
    end
  end

  assign pc_write     = ctl.pc_write;
  assign pc_sel_exc   = ctl.pc_sel_exc;
  assign if_id_write  = ctl.if_id_write;
  assign if_id_flush  = ctl.if_id_flush;
  assign id_ex_flush  = ctl.id_ex_flush;
  assign ex_mem_flush = ctl.ex_mem_flush;
  assign mem_wb_flush = ctl.mem_wb_flush;

  assign stall_inc = !reset && !ctl.pc_write;
  assign flush_inc = !reset && ctl.if_id_flush;

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a default instance plus a narrow-counter,
// single-cycle-exception instance driven by the same inputs.
module tb_pipe_ctrl;

  logic clock;
  logic reset;
  logic ID_EX_stall, id_uses_md, md_busy, ex_branch_taken, mem_exception;

  logic        pc_write, pc_sel_exc, if_id_write, if_id_flush;
  logic        id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [31:0] stall_cnt, flush_cnt;

  logic        s_pc_write, s_pc_sel_exc, s_if_id_write, s_if_id_flush;
  logic        s_id_ex_flush, s_ex_mem_flush, s_mem_wb_flush;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.EXC_FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .ID_EX_stall(ID_EX_stall), .id_uses_md(id_uses_md),
    .md_busy(md_busy), .ex_branch_taken(ex_branch_taken), .mem_exception(mem_exception),
    .pc_write(pc_write), .pc_sel_exc(pc_sel_exc), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl #(.EXC_FLUSH_CYCLES(1), .CNT_W(4)) dut_small (
    .clock(clock), .reset(reset), .ID_EX_stall(ID_EX_stall), .id_uses_md(id_uses_md),
    .md_busy(md_busy), .ex_branch_taken(ex_branch_taken), .mem_exception(mem_exception),
    .pc_write(s_pc_write), .pc_sel_exc(s_pc_sel_exc), .if_id_write(s_if_id_write),
    .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush), .ex_mem_flush(s_ex_mem_flush),
    .mem_wb_flush(s_mem_wb_flush), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, need $finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic stall, input logic uses_md, input logic busy,
                               input logic br, input logic exc);
    ID_EX_stall     = stall;
    id_uses_md      = uses_md;
    md_busy         = busy;
    ex_branch_taken = br;
    mem_exception   = exc;
  endtask

  // From posedge+1: move to mid-cycle where combinational strobes are stable
  task automatic midCycle();
    #4;
  endtask

  // Advance to just after the next rising edge
  task automatic nextEdge();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    nextEdge();
  endtask

  initial begin
    $display("[TB] starting pipe_ctrl bench");
    reset = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    #1;
    checkOutput("rst_pc_write", pc_write, 0);
    checkOutput("rst_if_id_write", if_id_write, 0);
    checkOutput("rst_if_id_flush", if_id_flush, 1);
    checkOutput("rst_id_ex_flush", id_ex_flush, 1);
    checkOutput("rst_ex_mem_flush", ex_mem_flush, 1);
    checkOutput("rst_mem_wb_flush", mem_wb_flush, 1);
    checkOutput("rst_pc_sel_exc", pc_sel_exc, 0);
    repeat (3) nextEdge();
    checkOutput("rst_stall_cnt", stall_cnt, 0);
    checkOutput("rst_flush_cnt", flush_cnt, 0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    midCycle();
    checkOutput("run_pc_write", pc_write, 1);
    checkOutput("run_if_id_write", if_id_write, 1);
    checkOutput("run_if_id_flush", if_id_flush, 0);
    checkOutput("run_id_ex_flush", id_ex_flush, 0);
    checkOutput("run_mem_wb_flush", mem_wb_flush, 0);
    nextEdge();

    // Single load-use stall
    doReset();
    applyStimulus(1, 0, 0, 0, 0);
    midCycle();
    checkOutput("lu_pc_write", pc_write, 0);
    checkOutput("lu_if_id_write", if_id_write, 0);
    checkOutput("lu_id_ex_flush", id_ex_flush, 1);
    checkOutput("lu_if_id_flush", if_id_flush, 0);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 0);
    midCycle();
    checkOutput("lu_after_pc_write", pc_write, 1);
    checkOutput("lu_after_id_ex_flush", id_ex_flush, 0);
    checkOutput("lu_stall_cnt", stall_cnt, 1);
    nextEdge();

    // Multiply/divide wait: id_uses_md only in the first cycle, wait held by MD_WAIT
    doReset();
    applyStimulus(0, 1, 1, 0, 0);
    midCycle();
    checkOutput("md_c1_pc_write", pc_write, 0);
    checkOutput("md_c1_id_ex_flush", id_ex_flush, 1);
    nextEdge();
    for (int i = 2; i <= 5; i++) begin
      applyStimulus(0, 0, 1, 0, 0);
      midCycle();
      checkOutput($sformatf("md_c%0d_pc_write", i), pc_write, 0);
      nextEdge();
    end
    applyStimulus(0, 0, 0, 0, 0);
    midCycle();
    checkOutput("md_done_pc_write", pc_write, 1);
    checkOutput("md_done_if_id_write", if_id_write, 1);
    checkOutput("md_done_id_ex_flush", id_ex_flush, 0);
    nextEdge();
    checkOutput("md_stall_cnt", stall_cnt, 5);

    // Branch squashes a same-cycle load-use stall
    doReset();
    applyStimulus(1, 0, 0, 1, 0);
    midCycle();
    checkOutput("br_pc_write", pc_write, 1);
    checkOutput("br_if_id_flush", if_id_flush, 1);
    checkOutput("br_id_ex_flush", id_ex_flush, 1);
    checkOutput("br_ex_mem_flush", ex_mem_flush, 0);
    checkOutput("br_pc_sel_exc", pc_sel_exc, 0);
    nextEdge();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("br_stall_cnt", stall_cnt, 0);
    checkOutput("br_flush_cnt", flush_cnt, 1);

    // Exception while waiting on the divider
    doReset();
    applyStimulus(0, 1, 1, 0, 0);
    nextEdge();
    applyStimulus(0, 0, 1, 0, 1);
    midCycle();
    checkOutput("exc_pc_sel_exc", pc_sel_exc, 1);
    checkOutput("exc_pc_write", pc_write, 1);
    checkOutput("exc_if_id_flush", if_id_flush, 1);
    checkOutput("exc_ex_mem_flush", ex_mem_flush, 1);
    checkOutput("exc_mem_wb_flush", mem_wb_flush, 1);
    checkOutput("exc1_pc_sel_exc", s_pc_sel_exc, 1);
    nextEdge();
    applyStimulus(0, 0, 1, 0, 0);
    midCycle();
    checkOutput("drain_pc_sel_exc", pc_sel_exc, 0);
    checkOutput("drain_pc_write", pc_write, 1);
    checkOutput("drain_id_ex_flush", id_ex_flush, 1);
    checkOutput("drain_mem_wb_flush", mem_wb_flush, 1);
    checkOutput("exc1_drain_if_id_flush", s_if_id_flush, 0);
    checkOutput("exc1_drain_pc_write", s_pc_write, 1);
    nextEdge();
    midCycle();
    checkOutput("post_exc_pc_write", pc_write, 1);
    checkOutput("post_exc_if_id_flush", if_id_flush, 0);
    checkOutput("post_exc_mem_wb_flush", mem_wb_flush, 0);
    nextEdge();
    checkOutput("exc_flush_cnt", flush_cnt, 2);
    checkOutput("exc_stall_cnt", stall_cnt, 1);
    checkOutput("exc1_flush_cnt", s_flush_cnt, 1);

    // Asynchronous reset aborts MD_WAIT immediately
    doReset();
    applyStimulus(0, 1, 1, 0, 0);
    nextEdge();
    applyStimulus(0, 0, 1, 0, 0);
    #2;
    checkOutput("abort_wait_pc_write", pc_write, 0);
    reset = 1'b1;
    #1;
    checkOutput("abort_rst_mem_wb_flush", mem_wb_flush, 1);
    checkOutput("abort_rst_stall_cnt", stall_cnt, 0);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("abort_run_pc_write", pc_write, 1);
    nextEdge();

    // Counter saturation on the narrow instance
    doReset();
    applyStimulus(1, 0, 0, 0, 0);
    repeat (14) nextEdge();
    checkOutput("sat_small_14", s_stall_cnt, 14);
    repeat (6) nextEdge();
    checkOutput("sat_small_20", s_stall_cnt, 15);
    checkOutput("sat_wide_20", stall_cnt, 20);
    applyStimulus(0, 0, 0, 0, 0);
    nextEdge();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
